dl_capture_ctrl: RTL and testbench

- Sequencer for the tapped-delay-line measurement path.
- Shares the delay line between two requesters: an external one-cycle trigger (for example a UART start-bit detect) and an internal periodic timer.
- For each granted request it toggles the launch pin, waits a settle time, and enables the capture shift register for exactly P_DL_LENGTH cycles.
- It then encodes the captured vector into an edge position and presents the result on a valid/ready handshake to the downstream formatter (UART TX).

---
 rtl/dl_pkg.sv | 37 +++
 rtl/dl_therm_encode.sv | 42 ++++
 rtl/dl_capture_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dl_capture_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dl_pkg.sv
// Shared types and width helpers for the tapped-delay-line capture path.
// Imported by dl_capture_ctrl and dl_therm_encode.
package dl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        ENCODE  = 3'd3,
        VALID   = 3'd4
    } dl_ctrl_sm_t;

    typedef enum logic {
        SRC_EXT  = 1'b0,
        SRC_AUTO = 1'b1
    } dl_src_t;

    localparam int unsigned DL_LENGTH_DEFAULT = 16;

    // Width of an edge position: 0..len inclusive.
    function automatic int unsigned dl_pos_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

    // One counter is shared by the settle and capture phases.
    function automatic int unsigned dl_cnt_width(input int unsigned settle,
                                                 input int unsigned len);
        int unsigned longest;
        longest = (settle > len) ? settle : len;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

    function automatic int unsigned dl_tmr_width(input int unsigned period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/dl_therm_encode.sv
// Combinational thermometer encoder: counts captured bits that match the launch level.
// With DL_CAPTURE_CTRL_BUBBLE_CHECK_EN it also flags vectors with more than one transition.
module dl_therm_encode
    import dl_pkg::*;
#(
    parameter int unsigned P_DL_LENGTH = DL_LENGTH_DEFAULT
) (
    input  logic [P_DL_LENGTH-1:0]               data,
    input  logic                                 level,
`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
    output logic                                 bubble,
`endif
    output logic [dl_pos_width(P_DL_LENGTH)-1:0] pos
);

    localparam int unsigned POS_W = dl_pos_width(P_DL_LENGTH);

    logic [P_DL_LENGTH-1:0] match;

    assign match = ~(data ^ {P_DL_LENGTH{level}});

    always_comb begin
        pos = '0;
        for (int i = 0; i < int'(P_DL_LENGTH); i++) begin
            pos = pos + POS_W'(match[i]);
        end
    end

`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
    logic [POS_W-1:0] edges;

    // A clean thermometer code has at most one boundary between adjacent taps.
    always_comb begin
        edges = '0;
        for (int i = 0; i < int'(P_DL_LENGTH) - 1; i++) begin
            edges = edges + POS_W'(data[i] ^ data[i+1]);
        end
        bubble = (edges > POS_W'(1));
    end
`endif

endmodule

// File: rtl/dl_capture_ctrl.sv
// Delay-line capture sequencer: arbitrates external/periodic requests, launches, captures, encodes.
// Define DL_CAPTURE_CTRL_BUBBLE_CHECK_EN to add the o_res_bubble output.
module dl_capture_ctrl
    import dl_pkg::*;
#(
    parameter int unsigned P_DL_LENGTH = 16,
    parameter int unsigned P_SETTLE    = 2,
    parameter int unsigned P_PERIOD    = 1000
) (
    input  logic                                 i_clk,
    input  logic                                 i_nrst,
    input  logic                                 i_req_ext,
    input  logic                                 i_auto_en,
    output logic                                 o_dl_tx,
    output logic                                 o_cap_en,
    input  logic [P_DL_LENGTH-1:0]               i_cap_data,
    output logic                                 o_res_valid,
    input  logic                                 i_res_ready,
    output logic [dl_pos_width(P_DL_LENGTH)-1:0] o_res_pos,
    output logic                                 o_res_rise,
    output logic                                 o_res_src,
`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
    output logic                                 o_res_bubble,
`endif
    output logic                                 o_drop,
    output logic                                 o_busy
);

    localparam int unsigned POS_W = dl_pos_width(P_DL_LENGTH);
    localparam int unsigned CNT_W = dl_cnt_width(P_SETTLE, P_DL_LENGTH);
    localparam int unsigned TMR_W = dl_tmr_width(P_PERIOD);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(P_SETTLE - 1);
    localparam logic [CNT_W-1:0] CAPTURE_LAST = CNT_W'(P_DL_LENGTH - 1);
    localparam logic [TMR_W-1:0] TIMER_LAST   = TMR_W'(P_PERIOD - 1);

    dl_ctrl_sm_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             ext_pend_q, ext_pend_d;
    logic             auto_pend_q, auto_pend_d;
    logic             prio_auto_q, prio_auto_d;
    logic             dl_tx_q, dl_tx_d;
    dl_src_t          src_q, src_d;
    logic [POS_W-1:0] res_pos_q, res_pos_d;
    logic             res_rise_q, res_rise_d;
    logic             res_src_q, res_src_d;
    logic             drop_q, drop_d;

    logic             grant_ext, grant_auto, grant;
    logic             auto_req;
    logic [POS_W-1:0] enc_pos;

`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
    logic             enc_bubble;
    logic             res_bubble_q, res_bubble_d;
`endif

    dl_therm_encode #(
        .P_DL_LENGTH(P_DL_LENGTH)
    ) u_encode (
        .data  (i_cap_data),
        .level (dl_tx_q),
`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
        .bubble(enc_bubble),
`endif
        .pos   (enc_pos)
    );

    assign auto_req = i_auto_en && (timer_q == TIMER_LAST);

    // Round-robin: prio_auto_q is set after an external grant so a tie then goes to auto.
    always_comb begin
        grant_ext  = 1'b0;
        grant_auto = 1'b0;
        if (state_q == IDLE) begin
            if (ext_pend_q && auto_pend_q) begin
                grant_auto = prio_auto_q;
                grant_ext  = !prio_auto_q;
            end else begin
                grant_ext  = ext_pend_q;
                grant_auto = auto_pend_q;
            end
        end
    end

    assign grant = grant_ext || grant_auto;

    // Request latching; a request arriving as its flag is granted away is kept, not dropped.
    always_comb begin
        timer_d     = '0;
        if (i_auto_en) begin
            timer_d = (timer_q == TIMER_LAST) ? '0 : timer_q + TMR_W'(1);
        end
        ext_pend_d  = i_req_ext || (ext_pend_q && !grant_ext);
        auto_pend_d = i_auto_en && (auto_req || (auto_pend_q && !grant_auto));
        drop_d      = (i_req_ext && ext_pend_q && !grant_ext) ||
                      (auto_req && auto_pend_q && !grant_auto);
        prio_auto_d = grant ? grant_ext : prio_auto_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dl_tx_d    = dl_tx_q;
        src_d      = src_q;
        res_pos_d  = res_pos_q;
        res_rise_d = res_rise_q;
        res_src_d  = res_src_q;
`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
        res_bubble_d = res_bubble_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    dl_tx_d = !dl_tx_q;
                    src_d   = grant_auto ? SRC_AUTO : SRC_EXT;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                if (cnt_q == CAPTURE_LAST) begin
                    state_d = ENCODE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ENCODE: begin
                state_d    = VALID;
                res_pos_d  = enc_pos;
                res_rise_d = dl_tx_q;
                res_src_d  = (src_q == SRC_AUTO);
`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
                res_bubble_d = enc_bubble;
`endif
            end
            VALID: begin
                if (i_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            timer_q     <= '0;
            ext_pend_q  <= 1'b0;
            auto_pend_q <= 1'b0;
            prio_auto_q <= 1'b0;
            dl_tx_q     <= 1'b1;
            src_q       <= SRC_EXT;
            res_pos_q   <= '0;
            res_rise_q  <= 1'b0;
            res_src_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            ext_pend_q  <= ext_pend_d;
            auto_pend_q <= auto_pend_d;
            prio_auto_q <= prio_auto_d;
            dl_tx_q     <= dl_tx_d;
            src_q       <= src_d;
            res_pos_q   <= res_pos_d;
            res_rise_q  <= res_rise_d;
            res_src_q   <= res_src_d;
            drop_q      <= drop_d;
        end
    end

`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            res_bubble_q <= 1'b0;
        end else begin
            res_bubble_q <= res_bubble_d;
        end
    end

    assign o_res_bubble = res_bubble_q;
`endif

    assign o_dl_tx     = dl_tx_q;
    assign o_cap_en    = (state_q == CAPTURE);
    assign o_res_valid = (state_q == VALID);
    assign o_busy      = (state_q != IDLE);
    assign o_res_pos   = res_pos_q;
    assign o_res_rise  = res_rise_q;
    assign o_res_src   = res_src_q;
    assign o_drop      = drop_q;

endmodule

// File: tb/tb_dl_capture_ctrl.sv
// Self-checking bench for dl_capture_ctrl: random capture data against a transaction-level model.
// Covers bubble reporting when DL_CAPTURE_CTRL_BUBBLE_CHECK_EN is defined.
module tb_dl_capture_ctrl;

    localparam int unsigned L   = 16;
    localparam int unsigned S   = 2;
    localparam int unsigned PER = 100;
    localparam int unsigned PW  = $clog2(L + 1);

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          req_ext = 1'b0;
    logic          auto_en = 1'b0;
    logic          ready = 1'b0;
    logic [L-1:0]  cap_data = '0;
    logic          dl_tx, cap_en, res_valid, res_rise, res_src, drop, busy;
    logic [PW-1:0] res_pos;
`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
    logic          res_bubble;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int drop_cnt = 0;
    int drop_cyc = -1;
    int src_log[$];
    int pos_log[$];
    logic lvl_m;

    dl_capture_ctrl #(
        .P_DL_LENGTH(L),
        .P_SETTLE   (S),
        .P_PERIOD   (PER)
    ) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_req_ext   (req_ext),
        .i_auto_en   (auto_en),
        .o_dl_tx     (dl_tx),
        .o_cap_en    (cap_en),
        .i_cap_data  (cap_data),
        .o_res_valid (res_valid),
        .i_res_ready (ready),
        .o_res_pos   (res_pos),
        .o_res_rise  (res_rise),
        .o_res_src   (res_src),
`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
        .o_res_bubble(res_bubble),
`endif
        .o_drop      (drop),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log accepted results and drop pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (nrst) begin
            if (drop) begin
                drop_cnt <= drop_cnt + 1;
                drop_cyc <= cyc;
            end
            if (res_valid && ready) begin
                src_log.push_back(int'(res_src));
                pos_log.push_back(int'(res_pos));
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_pos(input logic [L-1:0] d, input logic lvl);
        int n = 0;
        for (int i = 0; i < int'(L); i++) if (d[i] == lvl) n++;
        return n;
    endfunction

    function automatic logic exp_bubble(input logic [L-1:0] d);
        int n = 0;
        for (int i = 0; i < int'(L) - 1; i++) if (d[i] != d[i+1]) n++;
        return n > 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_dl_tx"}, dl_tx, 1);
        check_val({tag, "_cap_en"}, cap_en, 0);
        check_val({tag, "_valid"}, res_valid, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_drop"}, drop, 0);
        check_val({tag, "_pos"}, res_pos, 0);
        check_val({tag, "_rise_src"}, {res_rise, res_src}, 0);
    endtask

    task automatic reset_dut();
        nrst = 1'b0;
        req_ext = 1'b0;
        auto_en = 1'b0;
        ready = 1'b0;
        step();
        step();
        nrst = 1'b1;
        lvl_m = 1'b1;
        step();
    endtask

    // One external transaction: latency, window length, result and hold stability.
    task automatic run_ext(input logic [L-1:0] data, input int hold);
        int t0, rel;
        int tx_at = -1, cap_first = -1, cap_cnt = 0, valid_at = -1;
        logic lvl, stable;
        logic [PW-1:0] pos0;
        logic rise0, src0;
        lvl = ~lvl_m;
        step();
        cap_data = data;
        req_ext = 1'b1;
        t0 = cyc;
        step();
        req_ext = 1'b0;
        for (int i = 0; i < 60 && valid_at < 0; i++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (tx_at < 0 && dl_tx == lvl) tx_at = rel;
            if (cap_en) begin
                if (cap_first < 0) cap_first = rel;
                cap_cnt++;
            end
            if (res_valid) valid_at = rel;
        end
        check_val("tx_latency", tx_at, 2);
        check_val("cap_start", cap_first, 2 + S);
        check_val("cap_len", cap_cnt, L);
        check_val("valid_latency", valid_at, 2 + S + L + 1);
        check_val("res_pos", res_pos, exp_pos(data, lvl));
        check_val("res_rise", res_rise, lvl);
        check_val("res_src_ext", res_src, 0);
        check_val("busy_valid", busy, 1);
`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
        check_val("res_bubble", res_bubble, exp_bubble(data));
`endif
        lvl_m = lvl;
        pos0 = res_pos;
        rise0 = res_rise;
        src0 = res_src;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res_pos != pos0 || res_rise != rise0 || res_src != src0 || !res_valid || !busy)
                stable = 1'b0;
        end
        if (hold > 0) check_val("hold_stable", stable, 1);
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        @(negedge clk);
        check_val("valid_drop", res_valid, 0);
        check_val("busy_drop", busy, 0);
    endtask

    initial begin
        int a, t, base, d0, ntog, idle_ok, last_src, exp_s;
        int tog[$];
        logic prev;
        logic [L-1:0] rd;

        // Reset values, both during and after reset.
        nrst = 1'b0;
        step();
        @(negedge clk);
        check_idle("in_rst");
        step();
        nrst = 1'b1;
        lvl_m = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        run_ext(16'h00FF, 20);
        for (int k = 0; k < 5; k++) begin
            rd = L'($urandom);
            run_ext(rd, int'($urandom_range(0, 12)));
        end
`ifdef DL_CAPTURE_CTRL_BUBBLE_CHECK_EN
        run_ext(16'h00F7, 0);
        run_ext(16'h003F, 0);
`endif

        // Periodic auto grants with ready high.
        reset_dut();
        rd = L'($urandom);
        cap_data = rd;
        auto_en = 1'b1;
        ready = 1'b1;
        a = cyc;
        base = src_log.size();
        d0 = drop_cnt;
        prev = dl_tx;
        for (int i = 0; i < 340; i++) begin
            @(negedge clk);
            if (dl_tx != prev) tog.push_back(cyc);
            prev = dl_tx;
        end
        step();
        check_val("auto_toggles", tog.size(), 3);
        if (tog.size() >= 3) begin
            check_val("auto_period1", tog[1] - tog[0], PER);
            check_val("auto_period2", tog[2] - tog[1], PER);
        end
        check_val("auto_results", src_log.size() - base, 3);
        for (int k = base; k < src_log.size(); k++) begin
            lvl_m = ~lvl_m;
            check_val("auto_src", src_log[k], 1);
            check_val("auto_pos", pos_log[k], exp_pos(rd, lvl_m));
        end
        check_val("auto_no_drop", drop_cnt - d0, 0);

        // Result held: the second later wrap is lost.
        reset_dut();
        auto_en = 1'b1;
        ready = 1'b0;
        t = -1;
        prev = dl_tx;
        for (int i = 0; i < 150 && t < 0; i++) begin
            @(negedge clk);
            if (dl_tx != prev) t = cyc;
        end
        check_val("drop_first_grant", t >= 0, 1);
        d0 = drop_cnt;
        for (int i = 0; i < 250; i++) @(negedge clk);
        step();
        check_val("drop_count", drop_cnt - d0, 1);
        check_val("drop_second_wrap", (drop_cyc - t) >= 150 && (drop_cyc - t) <= 250, 1);
        check_val("drop_src", {res_valid, res_src}, 2'b11);
        auto_en = 1'b0;
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        idle_ok = 1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (busy || cap_en) idle_ok = 0;
        end
        check_val("auto_off_idle", idle_ok, 1);

        // External request coinciding with timer wrap, twice.
        reset_dut();
        rd = L'($urandom);
        cap_data = rd;
        auto_en = 1'b1;
        ready = 1'b1;
        a = cyc;
        base = src_log.size();
        d0 = drop_cnt;
        for (int rep = 0; rep < 2; rep++) begin
            while (cyc < a + PER - 1 + rep * PER) step();
            req_ext = 1'b1;
            step();
            req_ext = 1'b0;
        end
        while (cyc < a + 2 * PER + 90) step();
        check_val("coll_results", src_log.size() - base, 4);
        last_src = 1;
        ntog = 0;
        for (int k = base; k < src_log.size() && ntog < 4; k++) begin
            exp_s = (ntog % 2 == 0) ? 1 - last_src : last_src;
            if (ntog % 2 == 1) last_src = exp_s;
            lvl_m = ~lvl_m;
            check_val("coll_src", src_log[k], exp_s);
            check_val("coll_pos", pos_log[k], exp_pos(rd, lvl_m));
            ntog++;
        end
        check_val("coll_no_drop", drop_cnt - d0, 0);

        // Asynchronous reset while capturing.
        reset_dut();
        cap_data = L'($urandom);
        req_ext = 1'b1;
        step();
        req_ext = 1'b0;
        t = -1;
        for (int i = 0; i < 20 && t < 0; i++) begin
            @(negedge clk);
            if (cap_en) t = cyc;
        end
        check_val("rst_reach_capture", t >= 0, 1);
        step();
        step();
        #2 nrst = 1'b0;
        #1;
        check_val("arst_dl_tx", dl_tx, 1);
        check_val("arst_cap_en", cap_en, 0);
        check_val("arst_valid", res_valid, 0);
        check_val("arst_busy", busy, 0);
        step();
        nrst = 1'b1;
        idle_ok = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (res_valid || busy || dl_tx != 1'b1) idle_ok = 0;
        end
        check_val("arst_no_result", idle_ok, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
